// File: rtl/video_pkg.sv
// Shared video constants, frame-counter state encoding and the Sobel tap-sum helper.
package video_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned GRAD_W  = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } frame_state_e;

    // a + 2*b + c; the 4*255 worst case fits in GRAD_W bits
    function automatic logic [GRAD_W-1:0] tap_sum(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b,
                                                  input logic [PIX_W-1:0] c);
        return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
    endfunction

endpackage

// File: rtl/sobel_abs_diff.sv
// Registered absolute difference of two unsigned operands.
module sobel_abs_diff
    import video_pkg::*;
#(
    parameter int unsigned W = GRAD_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_abs
);

    logic [W-1:0] r_abs;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_abs <= '0;
        end else if (i_a >= i_b) begin
            r_abs <= i_a - i_b;
        end else begin
            r_abs <= i_b - i_a;
        end
    end

    assign o_abs = r_abs;

endmodule

// File: rtl/sobel_edge_detect_8bit.sv
// Four-stage Sobel gradient/threshold pipeline with a per-frame edge-pixel counter.
module sobel_edge_detect_8bit
    import video_pkg::*;
#(
    parameter logic [PIX_W-1:0] DEFAULT_THRESH = 8'd64,
    parameter int unsigned      CNT_W          = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             matrix_frame_vsync,
    input  logic             matrix_frame_href,
    input  logic [PIX_W-1:0] matrix_p11,
    input  logic [PIX_W-1:0] matrix_p12,
    input  logic [PIX_W-1:0] matrix_p13,
    input  logic [PIX_W-1:0] matrix_p21,
    input  logic [PIX_W-1:0] matrix_p22,
    input  logic [PIX_W-1:0] matrix_p23,
    input  logic [PIX_W-1:0] matrix_p31,
    input  logic [PIX_W-1:0] matrix_p32,
    input  logic [PIX_W-1:0] matrix_p33,
    input  logic [PIX_W-1:0] thresh_in,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic [PIX_W-1:0] post_img_Gray,
    output logic             post_img_Bit,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             edge_cnt_valid
);

    logic [LATENCY-1:0] r_vs_dly;
    logic [LATENCY-1:0] r_hs_dly;
    logic [LATENCY-1:0] r_vsg_dly;
    logic               r_armed;
    logic               r_vsg_prev;
    logic [PIX_W-1:0]   r_thresh;
    logic               w_vs_gated;
    logic               w_vs_rise;

    logic [GRAD_W-1:0]  r_gx_p, r_gx_n, r_gy_p, r_gy_n;
    logic [GRAD_W-1:0]  w_abs_gx, w_abs_gy;
    logic [GRAD_W:0]    w_g_sum;
    logic [GRAD_W:0]    r_g;
    logic [PIX_W-1:0]   r_gray_s3;
    logic [PIX_W-1:0]   r_gray;
    logic               r_bit;
    logic               w_unused_p22;

    frame_state_e       r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
    logic [CNT_W-1:0]   r_edge_cnt, w_edge_cnt_next;
    logic               r_valid, w_valid_next;
    logic               r_pv_prev;
    logic               w_pv;
    logic               w_hit;

    // The centre tap has zero weight in both kernels.
    assign w_unused_p22 = ^matrix_p22;

    // A frame already running at reset release stays unarmed until vsync has been seen low.
    assign w_vs_gated = matrix_frame_vsync & r_armed;
    assign w_vs_rise  = w_vs_gated & ~r_vsg_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_dly   <= '0;
            r_hs_dly   <= '0;
            r_vsg_dly  <= '0;
            r_armed    <= 1'b0;
            r_vsg_prev <= 1'b0;
            r_thresh   <= DEFAULT_THRESH;
        end else begin
            r_vs_dly   <= {r_vs_dly[LATENCY-2:0], matrix_frame_vsync};
            r_hs_dly   <= {r_hs_dly[LATENCY-2:0], matrix_frame_href};
            r_vsg_dly  <= {r_vsg_dly[LATENCY-2:0], w_vs_gated};
            r_armed    <= r_armed | ~matrix_frame_vsync;
            r_vsg_prev <= w_vs_gated;
            if (w_vs_rise) begin
                r_thresh <= thresh_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx_p <= '0;
            r_gx_n <= '0;
            r_gy_p <= '0;
            r_gy_n <= '0;
        end else begin
            r_gx_p <= tap_sum(matrix_p13, matrix_p23, matrix_p33);
            r_gx_n <= tap_sum(matrix_p11, matrix_p21, matrix_p31);
            r_gy_p <= tap_sum(matrix_p11, matrix_p12, matrix_p13);
            r_gy_n <= tap_sum(matrix_p31, matrix_p32, matrix_p33);
        end
    end

    sobel_abs_diff #(
        .W (GRAD_W)
    ) u_abs_gx (
        .i_clk (clk),
        .i_rst (rst),
        .i_a   (r_gx_p),
        .i_b   (r_gx_n),
        .o_abs (w_abs_gx)
    );

    sobel_abs_diff #(
        .W (GRAD_W)
    ) u_abs_gy (
        .i_clk (clk),
        .i_rst (rst),
        .i_a   (r_gy_p),
        .i_b   (r_gy_n),
        .o_abs (w_abs_gy)
    );

    assign w_g_sum = {1'b0, w_abs_gx} + {1'b0, w_abs_gy};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_g       <= '0;
            r_gray_s3 <= '0;
            r_gray    <= '0;
            r_bit     <= 1'b0;
        end else begin
            r_g       <= w_g_sum;
            r_gray_s3 <= (w_g_sum > (GRAD_W+1)'(255)) ? {PIX_W{1'b1}} : w_g_sum[PIX_W-1:0];
            r_gray    <= r_hs_dly[LATENCY-2] ? r_gray_s3 : '0;
            r_bit     <= (r_g > (GRAD_W+1)'(r_thresh)) & r_hs_dly[LATENCY-2];
        end
    end

    assign w_pv      = r_vsg_dly[LATENCY-1];
    assign w_hit     = r_hs_dly[LATENCY-1] & r_bit;
    assign w_cnt_inc = (w_hit && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_valid    <= 1'b0;
            r_pv_prev  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_valid    <= w_valid_next;
            r_pv_prev  <= w_pv;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_edge_cnt_next = r_edge_cnt;
        w_valid_next    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pv && !r_pv_prev) begin
                    w_state_next = COUNT;
                    w_cnt_next   = '0;
                end
            end
            COUNT: begin
                if (!w_pv) begin
                    w_state_next    = IDLE;
                    w_edge_cnt_next = w_cnt_inc;
                    w_valid_next    = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign post_frame_vsync = r_vs_dly[LATENCY-1];
    assign post_frame_href  = r_hs_dly[LATENCY-1];
    assign post_img_Gray    = r_gray;
    assign post_img_Bit     = r_bit;
    assign edge_cnt         = r_edge_cnt;
    assign edge_cnt_valid   = r_valid;

endmodule
